threshold_sweep_calibrator: RTL and testbench

Parametrised successor to the fixed dither-threshold calibrator. It sweeps NUM_CANDIDATES thresholds and discards SETTLE_FRAMES frames after each change to absorb dither-pipeline latency. It counts intra-line 0/1 transitions over one full frame per candidate, then locks the threshold with the most transitions. It sits between the dither stage (pixel feedback) and the threshold input of the same dither stage, and supports on-demand recalibration.

---
 rtl/calib_pkg.sv | 20 ++
 rtl/frame_position_counter.sv | 61 ++++++
 rtl/threshold_sweep_calibrator.sv | 197 +++++++++++++++++++
 tb/tb_threshold_sweep_calibrator.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calib_pkg.sv
// Shared types and helpers for the threshold sweep calibrator.
//   state_e      : sweep state (SETTLE, MEASURE, LOCKED)
//   THRESH_W     : width of the threshold driven to the dither stage
//   count_width  : transition counter width for an H x V frame
package calib_pkg;

  typedef enum logic [1:0] {
    SETTLE  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam int unsigned THRESH_W = 8;

  // Wide enough to hold H*V, the loose upper bound on a frame's transition count.
  function automatic int unsigned count_width(input int unsigned h, input int unsigned v);
    return $clog2(h * v + 1);
  endfunction

endpackage

// File: rtl/frame_position_counter.sv
// Raster position tracker. Advances only on valid pixels.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   pixel_valid    : a pixel is accepted this cycle
//   column, line   : position of the pixel currently presented
//   first_in_line  : current position is column 0
//   eof            : the valid pixel at (H_PIXELS-1, V_LINES-1) is being accepted
module frame_position_counter #(
  parameter int unsigned H_PIXELS = 320,
  parameter int unsigned V_LINES  = 240,
  localparam int unsigned COL_W   = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1,
  localparam int unsigned LINE_W  = (V_LINES > 1) ? $clog2(V_LINES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pixel_valid,
  output logic [COL_W-1:0]  column,
  output logic [LINE_W-1:0] line,
  output logic              first_in_line,
  output logic              eof
);

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_PIXELS - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_LINES - 1);

  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              col_wrap, line_wrap;

  assign col_wrap  = (col_q == COL_LAST);
  assign line_wrap = (line_q == LINE_LAST);

  always_comb begin
    col_d  = col_q;
    line_d = line_q;
    if (pixel_valid) begin
      if (col_wrap) begin
        col_d  = '0;
        line_d = line_wrap ? '0 : line_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q  <= '0;
      line_q <= '0;
    end else begin
      col_q  <= col_d;
      line_q <= line_d;
    end
  end

  assign column        = col_q;
  assign line          = line_q;
  assign first_in_line = (col_q == '0);
  assign eof           = pixel_valid && col_wrap && line_wrap;

endmodule

// File: rtl/threshold_sweep_calibrator.sv
// Sweeps NUM_CANDIDATES dither thresholds, discarding SETTLE_FRAMES frames after each
// change, counts intra-line 0/1 transitions over one measured frame per candidate and
// locks the threshold that produced the most transitions (ties keep the lower one).
// Optional feature macro: CALIB_TRACK_EN -- while locked, keep counting and request a
// new sweep when a frame drops below half the winning count.
// Ports:
//   clk_in, rst_in   : clock, synchronous active-low reset
//   pixel_in         : dithered pixel fed back from the dither stage
//   pixel_valid_in   : pixel_in qualifier, raster order
//   recal_in         : request a new sweep (applied at the next end of frame)
//   threshold_out    : threshold driven to the dither stage
//   calibrating_out  : sweep in progress
//   done_out         : threshold locked
//   best_count_out   : transition count of the winning candidate
module threshold_sweep_calibrator
  import calib_pkg::*;
#(
  parameter int unsigned H_PIXELS       = 320,
  parameter int unsigned V_LINES        = 240,
  parameter int unsigned NUM_CANDIDATES = 16,
  parameter int unsigned THRESH_START   = 0,
  parameter int unsigned THRESH_STEP    = 16,
  parameter int unsigned SETTLE_FRAMES  = 1,
  localparam int unsigned COUNT_W       = count_width(H_PIXELS, V_LINES)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                pixel_in,
  input  logic                pixel_valid_in,
  input  logic                recal_in,
  output logic [THRESH_W-1:0] threshold_out,
  output logic                calibrating_out,
  output logic                done_out,
  output logic [COUNT_W-1:0]  best_count_out
);

  localparam int unsigned COL_W       = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int unsigned LINE_W      = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int unsigned IDX_W       = (NUM_CANDIDATES > 1) ? $clog2(NUM_CANDIDATES) : 1;
  localparam int unsigned SET_W       = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;
  localparam int unsigned SETTLE_LAST = (SETTLE_FRAMES > 0) ? SETTLE_FRAMES - 1 : 0;
  localparam state_e      INIT_STATE  = (SETTLE_FRAMES == 0) ? MEASURE : SETTLE;
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_CANDIDATES - 1);
  localparam logic [THRESH_W-1:0] TH_START  = THRESH_W'(THRESH_START);
  localparam logic [THRESH_W-1:0] TH_STEP   = THRESH_W'(THRESH_STEP);

  if (NUM_CANDIDATES < 1) begin : g_bad_num
    $error("NUM_CANDIDATES must be at least 1");
  end
  if (NUM_CANDIDATES >= 1 &&
      THRESH_START + (NUM_CANDIDATES - 1) * THRESH_STEP > 255) begin : g_bad_range
    $error("last candidate threshold exceeds 255");
  end

  logic [COL_W-1:0]  column;
  logic [LINE_W-1:0] line;
  logic              first_in_line;
  logic              eof;

  frame_position_counter #(
    .H_PIXELS (H_PIXELS),
    .V_LINES  (V_LINES)
  ) u_pos (
    .clk           (clk_in),
    .rst_n         (rst_in),
    .pixel_valid   (pixel_valid_in),
    .column        (column),
    .line          (line),
    .first_in_line (first_in_line),
    .eof           (eof)
  );

  // Position itself is only needed through first_in_line/eof.
  logic unused_pos;
  assign unused_pos = ^{column, line};

  state_e              state_q, state_d;
  logic [THRESH_W-1:0] thresh_q, thresh_d;
  logic [THRESH_W-1:0] best_th_q, best_th_d;
  logic [COUNT_W-1:0]  best_q, best_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic                pend_q, pend_d;
  logic                prev_q, prev_d;

  logic               trans;
  logic [COUNT_W-1:0] count_next;
  logic               count_en;
  logic               take;

  assign trans      = pixel_valid_in && !first_in_line && (pixel_in != prev_q);
  assign count_next = count_q + COUNT_W'(trans);

`ifdef CALIB_TRACK_EN
  assign count_en = (state_q == MEASURE) || (state_q == LOCKED);
`else
  assign count_en = (state_q == MEASURE);
`endif

  // Winner update: first candidate always seeds, afterwards strictly greater only.
  assign take = (count_next > best_q) || (index_q == '0);

  always_comb begin
    state_d   = state_q;
    thresh_d  = thresh_q;
    best_th_d = best_th_q;
    best_d    = best_q;
    count_d   = count_q;
    index_d   = index_q;
    settle_d  = settle_q;
    pend_d    = pend_q | recal_in;
    prev_d    = pixel_valid_in ? pixel_in : prev_q;

    if (count_en) begin
      count_d = count_next;
    end

    if (eof) begin
      count_d = '0;
      if (pend_q) begin
        // Pending recal replaces whatever this frame would have done.
        state_d   = INIT_STATE;
        thresh_d  = TH_START;
        best_th_d = TH_START;
        best_d    = '0;
        index_d   = '0;
        settle_d  = '0;
        pend_d    = recal_in;
      end else begin
        unique case (state_q)
          SETTLE: begin
            if (settle_q == SET_W'(SETTLE_LAST)) begin
              settle_d = '0;
              state_d  = MEASURE;
            end else begin
              settle_d = settle_q + 1'b1;
            end
          end
          MEASURE: begin
            if (take) begin
              best_d    = count_next;
              best_th_d = thresh_q;
            end
            if (index_q == LAST_IDX) begin
              thresh_d = take ? thresh_q : best_th_q;
              state_d  = LOCKED;
            end else begin
              thresh_d = thresh_q + TH_STEP;
              index_d  = index_q + 1'b1;
              settle_d = '0;
              state_d  = INIT_STATE;
            end
          end
          LOCKED: begin
`ifdef CALIB_TRACK_EN
            if (count_next < (best_q >> 1)) begin
              pend_d = 1'b1;
            end
`endif
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= INIT_STATE;
      thresh_q  <= TH_START;
      best_th_q <= TH_START;
      best_q    <= '0;
      count_q   <= '0;
      index_q   <= '0;
      settle_q  <= '0;
      pend_q    <= 1'b0;
      prev_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      thresh_q  <= thresh_d;
      best_th_q <= best_th_d;
      best_q    <= best_d;
      count_q   <= count_d;
      index_q   <= index_d;
      settle_q  <= settle_d;
      pend_q    <= pend_d;
      prev_q    <= prev_d;
    end
  end

  assign threshold_out   = thresh_q;
  assign calibrating_out = (state_q != LOCKED);
  assign done_out        = (state_q == LOCKED);
  assign best_count_out  = best_q;

endmodule

// File: tb/tb_threshold_sweep_calibrator.sv
module tb_threshold_sweep_calibrator;

  localparam int H     = 4;
  localparam int V     = 2;
  localparam int NUM   = 4;
  localparam int START = 0;
  localparam int STEP  = 64;
  localparam int SET   = 1;
  localparam int FR    = H * V;
  localparam int CW    = $clog2(H * V + 1);

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          pixel_in = 1'b0;
  logic          pixel_valid_in = 1'b0;
  logic          recal_in = 1'b0;
  logic [7:0]    threshold_out;
  logic          calibrating_out;
  logic          done_out;
  logic [CW-1:0] best_count_out;

  threshold_sweep_calibrator #(
    .H_PIXELS       (H),
    .V_LINES        (V),
    .NUM_CANDIDATES (NUM),
    .THRESH_START   (START),
    .THRESH_STEP    (STEP),
    .SETTLE_FRAMES  (SET)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .pixel_in        (pixel_in),
    .pixel_valid_in  (pixel_valid_in),
    .recal_in        (recal_in),
    .threshold_out   (threshold_out),
    .calibrating_out (calibrating_out),
    .done_out        (done_out),
    .best_count_out  (best_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int th;
    int cal;
    int dn;
    int best;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: one call per completed frame, sweep rules in frame-level terms.
  int m_state;  // 0 settling, 1 measuring, 2 locked
  int m_settle, m_idx, m_th, m_best, m_bth;
  bit m_pend;

  task automatic model_reset();
    m_state  = (SET == 0) ? 1 : 0;
    m_settle = 0;
    m_idx    = 0;
    m_th     = START;
    m_best   = 0;
    m_bth    = START;
    m_pend   = 0;
  endtask

  function automatic int frame_total(input logic [FR-1:0] b);
    int t = 0;
    for (int l = 0; l < V; l++)
      for (int c = 1; c < H; c++)
        if (b[l*H+c] != b[l*H+c-1]) t++;
    return t;
  endfunction

  task automatic model_eof(input int t);
    exp_t e;
    if (m_pend) begin
      model_reset();
    end else if (m_state == 0) begin
      m_settle++;
      if (m_settle >= SET) begin
        m_settle = 0;
        m_state  = 1;
      end
    end else if (m_state == 1) begin
      if (t > m_best || m_idx == 0) begin
        m_best = t;
        m_bth  = m_th;
      end
      if (m_idx == NUM - 1) begin
        m_th    = m_bth;
        m_state = 2;
      end else begin
        m_th    = m_th + STEP;
        m_idx   = m_idx + 1;
        m_state = (SET == 0) ? 1 : 0;
      end
    end else begin
`ifdef CALIB_TRACK_EN
      if (t < m_best / 2) m_pend = 1;
`endif
    end
    e.th   = m_th;
    e.cal  = (m_state != 2);
    e.dn   = (m_state == 2);
    e.best = m_best;
    exp_q.push_back(e);
  endtask

  // Drives one frame; recal_at < 0 means no recal pulse, max_gap bounds idle cycles.
  task automatic send_frame(input logic [FR-1:0] b, input int recal_at, input int max_gap);
    int gap;
    for (int p = 0; p < FR; p++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
        @(negedge clk_in);
        pixel_valid_in = 1'b0;
        pixel_in       = 1'($urandom);
        recal_in       = 1'b0;
      end
      @(negedge clk_in);
      pixel_valid_in = 1'b1;
      pixel_in       = b[p];
      recal_in       = (p == recal_at);
      if (p == recal_at) m_pend = 1;
      if (p == FR - 1) model_eof(frame_total(b));
    end
    @(negedge clk_in);
    pixel_valid_in = 1'b0;
    recal_in       = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_threshold"}, threshold_out, START);
    chk({tag, "_calibrating"}, calibrating_out, 1);
    chk({tag, "_done"}, done_out, 0);
    chk({tag, "_best"}, best_count_out, 0);
  endtask

  // Monitor: tracks raster position from accepted pixels, checks after every EOF edge.
  int mon_pos = 0;
  always begin
    logic v, r;
    exp_t e;
    @(posedge clk_in);
    v = pixel_valid_in;
    r = rst_in;
    #1;
    if (!r) begin
      mon_pos = 0;
    end else if (v) begin
      if (mon_pos == FR - 1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL eof_unexpected: got output at %0t expected none queued", $time);
        end else begin
          e = exp_q.pop_front();
          chk("eof_threshold", threshold_out, e.th);
          chk("eof_calibrating", calibrating_out, e.cal);
          chk("eof_done", done_out, e.dn);
          chk("eof_best", best_count_out, e.best);
        end
      end
      mon_pos = (mon_pos + 1) % FR;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  localparam logic [FR-1:0] F_TWO   = 8'b1000_1000;  // 0001 / 0001 -> 2
  localparam logic [FR-1:0] F_SIX   = 8'b1010_1010;  // 0101 / 0101 -> 6
  localparam logic [FR-1:0] F_THREE = 8'b0000_1010;  // 0101 / 0000 -> 3

  initial begin
    int waited;
    model_reset();
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    chk_reset_outputs("reset");
    rst_in = 1'b1;

    // Directed sweep: junk settle frames between measured totals 2, 6, 6, 3.
    send_frame(FR'($urandom), -1, 0);
    send_frame(F_TWO, -1, 0);
    send_frame(FR'($urandom), -1, 0);
    send_frame(F_SIX, -1, 2);
    send_frame(FR'($urandom), -1, 0);
    send_frame(F_SIX, -1, 5);
    send_frame(FR'($urandom), -1, 0);
    send_frame(F_THREE, -1, 0);
    chk("lock_threshold", threshold_out, 64);
    chk("lock_best", best_count_out, 6);
    chk("lock_done", done_out, 1);

    // Low-activity frame while locked, then a frame that restarts the sweep either way.
    send_frame(F_TWO, -1, 0);
    send_frame(FR'($urandom), 2, 0);
    chk("restart_threshold", threshold_out, 0);
    chk("restart_calibrating", calibrating_out, 1);

    // Recal during candidate 2's measured frame discards that frame.
    send_frame(FR'($urandom), -1, 0);
    send_frame(F_SIX, -1, 0);
    send_frame(FR'($urandom), -1, 0);
    send_frame(F_THREE, -1, 0);
    send_frame(FR'($urandom), -1, 0);
    chk("cand2_threshold", threshold_out, 128);
    send_frame(F_SIX, 3, 0);
    chk("recal_threshold", threshold_out, 0);
    chk("recal_done", done_out, 0);
    chk("recal_best", best_count_out, 0);

    // Randomized frames with valid gaps and occasional recal pulses.
    for (int i = 0; i < 40; i++) begin
      send_frame(FR'($urandom), ($urandom_range(7, 0) == 0) ? int'($urandom_range(FR - 2, 0)) : -1,
                 ($urandom_range(1, 0) == 0) ? 0 : 5);
    end

    // Mid-frame reset: position restarts at column 0.
    for (int p = 0; p < 3; p++) begin
      @(negedge clk_in);
      pixel_valid_in = 1'b1;
      pixel_in       = 1'($urandom);
    end
    @(negedge clk_in);
    pixel_valid_in = 1'b0;
    rst_in         = 1'b0;
    @(negedge clk_in);
    chk_reset_outputs("midreset");
    rst_in = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      send_frame(FR'($urandom), -1, 3);
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(negedge clk_in);
      waited++;
    end
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
